// File: rtl/mem_stage_ls.sv
// MEM stage of the 5-stage in-order core: EX->MEM pipeline register, load-response
// tracking FSM, load alignment/extension and the WB / ID-forwarding buses.
module mem_stage_ls #(
   parameter int PC_W    = 32,
   parameter int REG_AW  = 5,
   parameter int STALL_W = 6,
   parameter int STG     = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               ex_valid,
   input  logic [PC_W-1:0]    ex_pc,
   input  logic               ex_ld,
   input  logic [2:0]         ex_ld_type,
   input  logic [1:0]         ex_addr_lo,
   input  logic               ex_rf_we,
   input  logic [REG_AW-1:0]  ex_rf_waddr,
   input  logic [31:0]        ex_result,
   input  logic [31:0]        data_sram_rdata,
   input  logic               data_sram_data_ok,
   output logic               mem_stallreq,
   output logic               wb_valid,
   output logic [PC_W-1:0]    wb_pc,
   output logic               wb_rf_we,
   output logic [REG_AW-1:0]  wb_rf_waddr,
   output logic [31:0]        wb_rf_wdata,
   output logic               fwd_we,
   output logic [REG_AW-1:0]  fwd_waddr,
   output logic [31:0]        fwd_wdata,
   output logic               fwd_ld_pending
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

   state_t             state_reg;
   logic               valid_reg;
   logic [PC_W-1:0]    pc_reg;
   logic               ld_reg;
   logic [2:0]         ld_type_reg;
   logic [1:0]         addr_lo_reg;
   logic               rf_we_reg;
   logic [REG_AW-1:0]  rf_waddr_reg;
   logic [31:0]        result_reg;
   logic [31:0]        cap_reg;

   logic               adv;
   logic               bubble;
   logic               ex_is_load;
   logic               waiting;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic [31:0]        ext_data;
   logic [31:0]        wdata;
   logic               unused_stall_bits;

   assign adv        = ~stall[STG];
   assign bubble     = stall[STG] & ~stall[STG+1];
   assign ex_is_load = ex_valid & ex_ld;
   assign waiting    = (state_reg == WAIT) & ~data_sram_data_ok;
   assign unused_stall_bits = ^stall;

   always_ff @(posedge clk) begin
      if (rst || flush || bubble) begin
         valid_reg    <= 1'b0;
         pc_reg       <= '0;
         ld_reg       <= 1'b0;
         ld_type_reg  <= 3'b000;
         addr_lo_reg  <= 2'b00;
         rf_we_reg    <= 1'b0;
         rf_waddr_reg <= '0;
         result_reg   <= 32'h0;
      end else if (adv) begin
         valid_reg    <= ex_valid;
         pc_reg       <= ex_pc;
         ld_reg       <= ex_ld;
         ld_type_reg  <= ex_ld_type;
         addr_lo_reg  <= ex_addr_lo;
         rf_we_reg    <= ex_rf_we;
         rf_waddr_reg <= ex_rf_waddr;
         result_reg   <= ex_result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cap_reg   <= 32'h0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!flush && adv && ex_is_load) state_reg <= WAIT;
            end
            WAIT: begin
               if (flush) begin
                  state_reg <= data_sram_data_ok ? IDLE : DRAIN;
               end else if (data_sram_data_ok) begin
                  if (adv) begin
                     state_reg <= ex_is_load ? WAIT : IDLE;
                  end else begin
                     // Downstream is stalled: keep the aligned data so WB can still take it later.
                     cap_reg   <= ext_data;
                     state_reg <= DONE;
                  end
               end
            end
            DONE: begin
               if (flush)    state_reg <= IDLE;
               else if (adv) state_reg <= ex_is_load ? WAIT : IDLE;
            end
            DRAIN: begin
               if (data_sram_data_ok) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      byte_sel = data_sram_rdata[7:0];
      case (addr_lo_reg)
         2'd1:    byte_sel = data_sram_rdata[15:8];
         2'd2:    byte_sel = data_sram_rdata[23:16];
         2'd3:    byte_sel = data_sram_rdata[31:24];
         default: byte_sel = data_sram_rdata[7:0];
      endcase
      half_sel = addr_lo_reg[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
      case (ld_type_reg)
         3'b001:  ext_data = {{24{byte_sel[7]}}, byte_sel};
         3'b010:  ext_data = {24'h0, byte_sel};
         3'b011:  ext_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  ext_data = {16'h0, half_sel};
         default: ext_data = data_sram_rdata;
      endcase
   end

   assign wdata = !ld_reg ? result_reg : ((state_reg == DONE) ? cap_reg : ext_data);

   assign mem_stallreq   = waiting | ((state_reg == DRAIN) & ~data_sram_data_ok);
   assign fwd_ld_pending = waiting;
   assign wb_valid       = valid_reg & ~waiting & (state_reg != DRAIN);
   assign wb_pc          = pc_reg;
   assign wb_rf_we       = rf_we_reg & wb_valid;
   assign wb_rf_waddr    = rf_waddr_reg;
   assign wb_rf_wdata    = wdata;
   assign fwd_we         = wb_rf_we;
   assign fwd_waddr      = wb_valid ? rf_waddr_reg : '0;
   assign fwd_wdata      = wb_valid ? wdata : 32'h0;

endmodule
